pipe_register: RTL and testbench
================================

PIPE_REGISTER -- requirements
Module: pipe_register

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data width in bits (legal >= 1).
REQ-002 The block SHALL have parameter STAGES, default 4, number of register stages (legal 1..16).
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst_  input  1  asynchronous, active-low reset.
REQ-005 Port enable  input  1  global advance enable; 0 = whole pipe holds.
REQ-006 Port flush  input  1  synchronous clear of all stage valid bits.
REQ-007 Port data  input  WIDTH  upstream data word.
REQ-008 Port in_valid  input  1  upstream word present on data.
REQ-009 Port in_ready  output  1  block accepts data this cycle.
REQ-010 Port out  output  WIDTH  data of last stage.
REQ-011 Port out_valid  output  1  last stage holds a valid word.
REQ-012 Port out_ready  input  1  downstream accepts out this cycle.
REQ-013 Port count  output  $clog2(STAGES+1)  number of valid stages.

Function
REQ-014 Each stage i SHALL hold a WIDTH-bit data register and a valid bit; stage 0 faces the input, stage STAGES-1 drives out/out_valid.
REQ-015 Last stage SHALL be able to accept when !valid[STAGES-1] or out_ready; stage i < STAGES-1 SHALL be able to accept when !valid[i] or stage i+1 moves (combinational ready chain, bubbles collapse).
REQ-016 in_ready SHALL equal enable & !flush & (stage 0 able to accept).
REQ-017 Input transfer SHALL occur on a rising edge with in_valid & in_ready; output transfer on out_valid & out_ready & enable & !flush.
REQ-018 When a stage moves, it SHALL load the data/valid of its predecessor (stage 0 loads data/in_valid); when it does not move, data and valid SHALL hold.
REQ-019 With enable=0, no stage SHALL change, in_ready SHALL be 0 and out_valid SHALL remain visible (out is not consumed).
REQ-020 With flush=1 on a rising edge, all valid bits SHALL clear, data registers SHALL hold, the input word SHALL be dropped, count SHALL become 0; flush SHALL take priority over enable and every transfer.
REQ-021 Latency: into an empty pipe with out_ready=1, a word accepted at edge k SHALL appear with out_valid=1 after edge k+STAGES-1 (i.e. STAGES cycles after presentation).
REQ-022 Full pipe (count=STAGES) with out_ready=1 SHALL accept and emit one word per cycle (full throughput); with out_ready=0 in_ready SHALL be 0.
REQ-023 Simultaneous input and output transfer SHALL leave count unchanged; input-only +1; output-only -1.
REQ-024 Words SHALL leave in acceptance order; no word SHALL be duplicated or lost except by flush or reset.
REQ-025 out SHALL be driven by the last stage register regardless of out_valid.

Reset
REQ-026 On rst_=0, asynchronously and independent of clk, all valid bits SHALL be 0, all data registers 0, count 0, out 0, out_valid 0.
REQ-027 in_ready SHALL be 0 while rst_=0; normal operation SHALL start on the first rising edge after rst_ deasserts.
REQ-028 Reset asserted mid-transfer SHALL discard all in-flight words.

Structure
REQ-029 Package pipe_register_pkg SHALL hold default WIDTH/STAGES constants and the count-width function.
REQ-030 One sub-module pipe_stage (WIDTH-parameterised data+valid register with load/hold and async reset) SHALL be instantiated STAGES times via generate.
REQ-031 count SHALL be a registered up/down counter, not a popcount.

Verification
REQ-032 Reset: rst_=0 at arbitrary time with X data -> out=00, out_valid=0, count=0, in_ready=0 immediately.
REQ-033 Latency: STAGES=4, empty pipe, out_ready=1, push AA -> out=AA, out_valid=1 exactly 4 cycles after presentation, count returns to 0.
REQ-034 Backpressure: out_ready=0, push 01,02,03,04,05 -> first four accepted, count=4, in_ready=0 at 05; release out_ready -> 01..05 emitted in order, one per cycle.
REQ-035 Stall: pipe holding 55,66, enable=0 for 3 cycles with in_valid=1 and out_ready=1 -> no change, count=2, in_ready=0; enable=1 resumes, 55 emitted first.
REQ-036 Flush: count=3, assert flush with in_valid=1, data=77 -> next cycle count=0, out_valid=0, 77 never emitted.
REQ-037 Parameter sweep: STAGES=1 and WIDTH=32 with random valid/ready -> scoreboard order match, no loss, count never exceeds STAGES.

Source files
------------

// File: rtl/pipe_register_pkg.sv
// pipe_register_pkg
//   Shared constants for the pipe_register slice: default data width, default
//   stage count and the helper that sizes the occupancy counter.
package pipe_register_pkg;

  localparam int DEFAULT_WIDTH  = 8;
  localparam int DEFAULT_STAGES = 4;

  // Bits needed to hold an occupancy value in 0..stages inclusive.
  function automatic int count_width(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// pipe_stage
//   One pipeline slot: a WIDTH-bit data register plus its valid bit.
//   Ports:
//     clk, rst_  - clock, asynchronous active-low reset (clears data and valid)
//     load       - capture d/d_valid on the rising edge
//     clear      - drop the valid bit, data holds; wins over load
//     d, d_valid - word and valid bit offered by the predecessor
//     q, q_valid - registered word and valid bit
module pipe_stage
  import pipe_register_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      q       <= '0;
      q_valid <= 1'b0;
    end else if (clear) begin
      q_valid <= 1'b0;
    end else if (load) begin
      q       <= d;
      q_valid <= d_valid;
    end
  end

endmodule

// File: rtl/pipe_register.sv
// pipe_register
//   STAGES-deep register pipeline with per-stage valid bits, a combinational
//   ready chain that lets bubbles collapse, a global stall (enable) and a
//   synchronous flush that invalidates every stage.
//   Ports:
//     clk, rst_           - clock, asynchronous active-low reset
//     enable              - 0 freezes the whole pipe
//     flush               - clears all valid bits on the edge; beats everything
//     data, in_valid      - upstream word and its valid
//     in_ready            - pipe takes the upstream word this cycle
//     out, out_valid      - last-stage word (always driven) and its valid
//     out_ready           - downstream takes out this cycle
//     count               - registered number of valid stages
//
//   Handshake: a word moves across an interface on a rising edge only when
//   its valid and ready are both high in the cycle before that edge. Upstream
//   transfer is in_valid & in_ready; downstream transfer is
//   out_valid & out_ready & enable & !flush. in_ready never depends on
//   in_valid, and out_valid never depends on out_ready.
module pipe_register
  import pipe_register_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic                            clk,
  input  logic                            rst_,
  input  logic                            enable,
  input  logic                            flush,
  input  logic [WIDTH-1:0]                data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [WIDTH-1:0]                out,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [count_width(STAGES)-1:0]  count
);

  localparam int CW = count_width(STAGES);

  logic [WIDTH-1:0] stage_q  [STAGES];
  logic             stage_v  [STAGES];
  logic [WIDTH-1:0] stage_d  [STAGES];
  logic             stage_dv [STAGES];

  // mv[i] = stage i loads this edge; mv[STAGES] stands for the downstream
  // consumer so the chain below has a uniform shape at every stage.
  logic [STAGES:0]  mv;
  logic             advance;
  logic             in_xfer;
  logic             out_xfer;

  assign advance = enable & ~flush;

  // A stage may load when it is empty or its successor is loading. Walking
  // from the output back to the input lets an empty slot anywhere in the
  // pipe pull everything upstream of it forward in the same cycle.
  always_comb begin
    mv         = '0;
    mv[STAGES] = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      mv[i] = advance & (~stage_v[i] | mv[i+1]);
    end
  end

  // Gating with rst_ keeps in_ready low for the whole reset, since an empty
  // pipe would otherwise report ready.
  assign in_ready  = rst_ & mv[0];
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = stage_v[STAGES-1] & out_ready & advance;
  assign out       = stage_q[STAGES-1];
  assign out_valid = stage_v[STAGES-1];

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign stage_d[g]  = data;
      assign stage_dv[g] = in_valid;
    end else begin : g_body
      assign stage_d[g]  = stage_q[g-1];
      assign stage_dv[g] = stage_v[g-1];
    end

    pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk     (clk),
      .rst_    (rst_),
      .load    (mv[g]),
      .clear   (flush),
      .d       (stage_d[g]),
      .d_valid (stage_dv[g]),
      .q       (stage_q[g]),
      .q_valid (stage_v[g])
    );
  end

  // Occupancy tracks transfers rather than summing valid bits.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (in_xfer && !out_xfer) begin
      count <= count + CW'(1);
    end else if (out_xfer && !in_xfer) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: tb/tb_pipe_register.sv
// tb_pipe_register
//   Two instances: dut_a (WIDTH 8, STAGES 4) takes directed scenarios and
//   random traffic; dut_b (WIDTH 32, STAGES 1) takes random traffic only.
//   Each has a reference model: an ordered queue of accepted words whose
//   length is the expected occupancy, with acceptance derived from capacity.
module tb_pipe_register;

  localparam int WA  = 8;
  localparam int SA  = 4;
  localparam int WB  = 32;
  localparam int SB  = 1;
  localparam int CWA = $clog2(SA + 1);
  localparam int CWB = $clog2(SB + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_;
  always #5 clk = ~clk;

  // ---------------- dut_a ----------------
  logic           a_en, a_fl, a_iv, a_ir, a_ov, a_or;
  logic [WA-1:0]  a_d, a_out;
  logic [CWA-1:0] a_cnt;

  pipe_register #(.WIDTH(WA), .STAGES(SA)) dut_a (
    .clk       (clk),
    .rst_      (rst_),
    .enable    (a_en),
    .flush     (a_fl),
    .data      (a_d),
    .in_valid  (a_iv),
    .in_ready  (a_ir),
    .out       (a_out),
    .out_valid (a_ov),
    .out_ready (a_or),
    .count     (a_cnt)
  );

  // ---------------- dut_b ----------------
  logic           b_en, b_fl, b_iv, b_ir, b_ov, b_or;
  logic [WB-1:0]  b_d, b_out;
  logic [CWB-1:0] b_cnt;

  pipe_register #(.WIDTH(WB), .STAGES(SB)) dut_b (
    .clk       (clk),
    .rst_      (rst_),
    .enable    (b_en),
    .flush     (b_fl),
    .data      (b_d),
    .in_valid  (b_iv),
    .in_ready  (b_ir),
    .out       (b_out),
    .out_valid (b_ov),
    .out_ready (b_or),
    .count     (b_cnt)
  );

  // ---------------- scoreboard state ----------------
  logic [WA-1:0] exp_q[$];
  logic [WB-1:0] exp_q_b[$];
  int n_cmp = 0;
  int n_err = 0;
  bit b_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitors (sample at falling edge) ----------------
  always @(negedge clk) begin : mon_a
    logic          exp_ir;
    logic [WA-1:0] w;
    if (!rst_) begin
      exp_q.delete();
    end else begin
      // A pipe with a free slot anywhere can always take a word; a full one
      // only when its head leaves in the same cycle.
      exp_ir = a_en && !a_fl && ((exp_q.size() < SA) || a_or);
      check("a_in_ready", a_ir, exp_ir);
      check("a_count", a_cnt, exp_q.size());
      check("a_count_max", (a_cnt <= SA), 1);
      if (exp_q.size() == 0) check("a_out_valid_empty", a_ov, 0);
      if (a_fl) begin
        exp_q.delete();
      end else begin
        if (a_ov && a_or && a_en) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL a_out_order: got %0h expected no word at %0t", a_out, $time);
          end else begin
            w = exp_q.pop_front();
            check("a_out_order", a_out, w);
          end
        end
        if (a_iv && exp_ir) exp_q.push_back(a_d);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    logic          exp_ir;
    logic [WB-1:0] w;
    if (!rst_) begin
      exp_q_b.delete();
    end else begin
      exp_ir = b_en && !b_fl && ((exp_q_b.size() < SB) || b_or);
      check("b_in_ready", b_ir, exp_ir);
      check("b_count", b_cnt, exp_q_b.size());
      check("b_count_max", (b_cnt <= SB), 1);
      if (exp_q_b.size() == 0) check("b_out_valid_empty", b_ov, 0);
      if (b_fl) begin
        exp_q_b.delete();
      end else begin
        if (b_ov && b_or && b_en) begin
          if (exp_q_b.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL b_out_order: got %0h expected no word at %0t", b_out, $time);
          end else begin
            w = exp_q_b.pop_front();
            check("b_out_order", b_out, w);
          end
        end
        if (b_iv && exp_ir) exp_q_b.push_back(b_d);
      end
    end
  end

  // ---------------- dut_b driver: random traffic ----------------
  initial begin
    b_en = 1'b0; b_fl = 1'b0; b_iv = 1'b0; b_or = 1'b0; b_d = '0;
    @(posedge rst_);
    for (int i = 0; i < 3000; i++) begin
      tick();
      b_en = ($urandom_range(0, 9) != 0);
      b_fl = ($urandom_range(0, 49) == 0);
      b_iv = $urandom_range(0, 1);
      b_or = ($urandom_range(0, 9) < 7);
      b_d  = $urandom;
    end
    tick();
    b_en = 1'b1; b_fl = 1'b0; b_iv = 1'b0; b_or = 1'b1;
    repeat (2 * SB + 4) tick();
    #1;
    check("b_drain_empty", exp_q_b.size(), 0);
    check("b_drain_count", b_cnt, 0);
    b_done = 1'b1;
  end

  // ---------------- dut_a driver: directed + random ----------------
  initial begin
    rst_ = 1'b0;
    a_en = 1'b1; a_fl = 1'b0; a_iv = 1'b1; a_or = 1'b1; a_d = 'x;

    // Reset state with enable high and X data on the input.
    #12;
    check("rst_out", a_out, 0);
    check("rst_out_valid", a_ov, 0);
    check("rst_count", a_cnt, 0);
    check("rst_in_ready", a_ir, 0);
    a_iv = 1'b0;
    @(posedge clk);
    #2 rst_ = 1'b1;

    // Latency through an empty pipe.
    a_en = 1'b1; a_fl = 1'b0; a_iv = 1'b1; a_d = 8'hAA; a_or = 1'b1;
    #1 check("lat_in_ready", a_ir, 1);
    tick();
    a_iv = 1'b0;
    for (int i = 1; i <= SA; i++) begin
      if (i > 1) tick();
      #1 check("lat_out_valid", a_ov, (i == SA));
    end
    check("lat_out", a_out, 8'hAA);
    tick();
    #1 check("lat_count_drained", a_cnt, 0);

    // Backpressure: fill to capacity, then release.
    a_or = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      a_iv = 1'b1;
      a_d  = v[WA-1:0];
      #1 check("bp_in_ready", a_ir, (v < 5));
      if (v == 5) check("bp_count_full", a_cnt, 4);
      tick();
    end
    a_or = 1'b1;
    #1 check("bp_in_ready_release", a_ir, 1);
    for (int j = 1; j <= 5; j++) begin
      #1;
      check("bp_out_valid", a_ov, 1);
      check("bp_out_seq", a_out, j);
      tick();
      a_iv = 1'b0;
    end
    #1;
    check("bp_count_drained", a_cnt, 0);
    check("bp_out_valid_end", a_ov, 0);

    // Stall with two words resident.
    a_or = 1'b0; a_iv = 1'b1; a_d = 8'h55;
    tick();
    a_d = 8'h66;
    tick();
    a_iv = 1'b0;
    repeat (SA) tick();
    #1;
    check("stall_pre_count", a_cnt, 2);
    check("stall_pre_out", a_out, 8'h55);
    a_en = 1'b0; a_iv = 1'b1; a_d = 8'h99; a_or = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_in_ready", a_ir, 0);
      check("stall_count", a_cnt, 2);
      check("stall_out_valid", a_ov, 1);
      check("stall_out", a_out, 8'h55);
      tick();
    end
    a_en = 1'b1;
    #1 check("stall_resume_out", a_out, 8'h55);
    tick();
    a_iv = 1'b0;
    repeat (SA + 2) tick();
    #1 check("stall_count_drained", a_cnt, 0);

    // Flush with three words resident and a word on the input.
    a_or = 1'b0;
    a_iv = 1'b1; a_d = 8'hA1; tick();
    a_d = 8'hA2; tick();
    a_d = 8'hA3; tick();
    a_iv = 1'b0;
    repeat (SA) tick();
    #1;
    check("flush_pre_count", a_cnt, 3);
    check("flush_pre_out", a_out, 8'hA1);
    a_fl = 1'b1; a_iv = 1'b1; a_d = 8'h77; a_or = 1'b1;
    #1 check("flush_in_ready", a_ir, 0);
    tick();
    a_fl = 1'b0; a_iv = 1'b0;
    #1;
    check("flush_count", a_cnt, 0);
    check("flush_out_valid", a_ov, 0);
    check("flush_data_held", a_out, 8'hA1);
    repeat (SA + 2) tick();
    #1 check("flush_no_emit", a_ov, 0);

    // Random traffic with an asynchronous reset in the middle.
    for (int i = 0; i < 1500; i++) begin
      tick();
      a_en = ($urandom_range(0, 9) != 0);
      a_fl = ($urandom_range(0, 39) == 0);
      a_iv = $urandom_range(0, 1);
      a_or = ($urandom_range(0, 3) != 0);
      a_d  = $urandom_range(0, 255);
      if (i == 700) begin
        #2;
        rst_ = 1'b0;
        a_iv = 1'b0;
        a_d  = 'x;
        #1;
        check("midrst_out", a_out, 0);
        check("midrst_out_valid", a_ov, 0);
        check("midrst_count", a_cnt, 0);
        check("midrst_in_ready", a_ir, 0);
        check("midrst_b_out", b_out, 0);
        check("midrst_b_out_valid", b_ov, 0);
        check("midrst_b_count", b_cnt, 0);
        check("midrst_b_in_ready", b_ir, 0);
        repeat (2) @(posedge clk);
        #2 rst_ = 1'b1;
      end
    end

    // Drain and confirm nothing was lost.
    tick();
    a_en = 1'b1; a_fl = 1'b0; a_iv = 1'b0; a_or = 1'b1;
    repeat (2 * SA + 4) tick();
    #1;
    check("a_drain_empty", exp_q.size(), 0);
    check("a_drain_count", a_cnt, 0);

    for (int i = 0; i < 20000 && !b_done; i++) @(posedge clk);
    if (!b_done) begin
      n_cmp++;
      n_err++;
      $display("FAIL b_done_timeout: got 0 expected 1");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Absolute time bound.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

endmodule
